mv_seq_ctrl: RTL and testbench



---
 rtl/mv_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_mv_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mv_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mv_seq_ctrl : SPI command decoder, operand loader and PE-array sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module mv_seq_ctrl #(
  parameter int                   ADDR_SIZE = 10,
  parameter int                   WORD_SIZE = 16,
  parameter int                   PE_NUMBER = 64,
  parameter int                   MAX_COLS  = 64,
  parameter logic [ADDR_SIZE-1:0] MEM_BASE  = 'h00f,
  parameter logic [ADDR_SIZE-1:0] ZERO_ADDR = '1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [WORD_SIZE-1:0]           cmd_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [WORD_SIZE-1:0]           rsp_data,
  output logic                           mem_w_en,
  output logic [ADDR_SIZE-1:0]           mem_w_addr,
  output logic [WORD_SIZE-1:0]           mem_w_data,
  output logic                           mem_r_en,
  output logic [ADDR_SIZE-1:0]           mem_r_addr,
  input  logic [WORD_SIZE-1:0]           mem_r_data,
  output logic                           arr_clear,
  output logic [ADDR_SIZE-1:0]           vec_addr,
  output logic [PE_NUMBER*ADDR_SIZE-1:0] pe_addr,
  input  logic                           arr_res_valid,
  input  logic [WORD_SIZE-1:0]           arr_res_data,
  output logic                           busy
);

  localparam int AW2 = ADDR_SIZE + 2;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_STATUS    = 4'd1,
    S_LOAD_VEC  = 4'd2,
    S_LOAD_MAT  = 4'd3,
    S_FETCH     = 4'd4,
    S_CAL_WAIT  = 4'd5,
    S_DRAIN     = 4'd6,
    S_READ_ADDR = 4'd7,
    S_READ_MEM  = 4'd8,
    S_READ_CAP  = 4'd9,
    S_READ_HOLD = 4'd10
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             rows_q, rows_d, cols_q, cols_d;
  logic                   err_q, err_d, done_q, done_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [8:0]             t_q, t_d;
  logic [7:0]             col_q, col_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0]   rsp_data_q, rsp_data_d;
  logic                   mem_w_en_q, mem_w_en_d;
  logic [ADDR_SIZE-1:0]   mem_w_addr_q, mem_w_addr_d;
  logic [WORD_SIZE-1:0]   mem_w_data_q, mem_w_data_d;
  logic                   mem_r_en_q, mem_r_en_d;
  logic [ADDR_SIZE-1:0]   mem_r_addr_q, mem_r_addr_d;

  logic [AW2-1:0] w_rows, w_cols, w_t, w_base, w_mat_base, w_res_base, w_lane_base;
  logic [15:0]    w_total;
  logic [7:0]     w_tmax;
  logic [8:0]     w_span, w_t_nxt;
  logic [3:0]     w_op;
  logic           w_acc, w_fetch, w_lane_on;

  // Layout arithmetic is carried two bits wider than the address bus, then truncated
  assign w_rows      = AW2'(rows_q);
  assign w_cols      = AW2'(cols_q);
  assign w_t         = AW2'(t_q);
  assign w_base      = AW2'(MEM_BASE);
  assign w_mat_base  = w_base + w_rows;
  assign w_res_base  = w_mat_base + w_rows * w_cols;
  assign w_lane_base = w_mat_base + w_t * w_rows;
  assign w_total     = {8'd0, rows_q} * {8'd0, cols_q};
  assign w_tmax      = (rows_q > cols_q) ? rows_q : cols_q;
  assign w_span      = {1'b0, rows_q} + {1'b0, cols_q} - 9'd1;
  assign w_t_nxt     = t_q + 9'd1;
  assign w_op        = cmd_data[15:12];
  assign w_acc       = cmd_valid && cmd_ready_q;
  assign w_fetch     = (state_q == S_FETCH);
  assign w_lane_on   = w_fetch && (t_q < {1'b0, cols_q});

  assign busy       = state_q inside {S_FETCH, S_CAL_WAIT, S_DRAIN};
  assign arr_clear  = !busy;
  assign vec_addr   = (w_fetch && (t_q < {1'b0, rows_q})) ? ADDR_SIZE'(w_base + w_t) : ZERO_ADDR;
  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign mem_w_en   = mem_w_en_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_w_data = mem_w_data_q;
  assign mem_r_en   = mem_r_en_q;
  assign mem_r_addr = mem_r_addr_q;

  for (genvar i = 0; i < PE_NUMBER; i++) begin : g_lane
    assign pe_addr[i*ADDR_SIZE +: ADDR_SIZE] =
      (w_lane_on && (8'(i) < rows_q)) ? ADDR_SIZE'(w_lane_base + AW2'(i)) : ZERO_ADDR;
  end

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    err_d        = err_q;
    done_d       = done_q;
    cnt_d        = cnt_q;
    t_d          = t_q;
    col_d        = col_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    mem_w_en_d   = 1'b0;
    mem_w_addr_d = mem_w_addr_q;
    mem_w_data_d = mem_w_data_q;
    mem_r_en_d   = 1'b0;
    mem_r_addr_d = mem_r_addr_q;

    case (state_q)
      S_IDLE: begin
        if (w_acc) begin
          case (w_op)
            4'd1: begin
              if (cmd_data[7:0] == 8'd0 || int'(cmd_data[7:0]) > PE_NUMBER) err_d = 1'b1;
              else rows_d = cmd_data[7:0];
            end
            4'd2: begin
              if (cmd_data[7:0] == 8'd0 || int'(cmd_data[7:0]) > MAX_COLS) err_d = 1'b1;
              else cols_d = cmd_data[7:0];
            end
            4'd3: begin
              state_d = S_FETCH;
              done_d  = 1'b0;
              t_d     = 9'd0;
            end
            4'd4: begin
              state_d = S_LOAD_VEC;
              cnt_d   = 16'd0;
            end
            4'd5: begin
              state_d = S_LOAD_MAT;
              cnt_d   = 16'd0;
            end
            4'd6: begin
              if (done_q) begin
                state_d = S_READ_ADDR;
                col_d   = 8'd0;
              end else begin
                err_d = 1'b1;
              end
            end
            4'd7: begin
              // Snapshot err before clearing it so the reader sees the sticky flag once
              rsp_valid_d = 1'b1;
              rsp_data_d  = WORD_SIZE'({busy, done_q, err_q, 5'b0, rows_q});
              err_d       = 1'b0;
              state_d     = S_STATUS;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      S_STATUS: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_LOAD_VEC: begin
        if (w_acc) begin
          mem_w_en_d   = 1'b1;
          mem_w_addr_d = ADDR_SIZE'(w_base + AW2'(cnt_q));
          mem_w_data_d = cmd_data;
          cnt_d        = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == {8'd0, rows_q}) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end
        end
      end

      S_LOAD_MAT: begin
        if (w_acc) begin
          mem_w_en_d   = 1'b1;
          mem_w_addr_d = ADDR_SIZE'(w_mat_base + AW2'(cnt_q));
          mem_w_data_d = cmd_data;
          cnt_d        = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == w_total) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end
        end
      end

      S_FETCH: begin
        t_d = w_t_nxt;
        if (w_t_nxt == {1'b0, w_tmax}) begin
          // With a unit dimension the pipeline is already full when fetch ends
          col_d   = 8'd0;
          state_d = (w_t_nxt >= w_span) ? S_DRAIN : S_CAL_WAIT;
        end
      end

      S_CAL_WAIT: begin
        t_d = w_t_nxt;
        if (w_t_nxt >= w_span) begin
          col_d   = 8'd0;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (arr_res_valid) begin
          mem_w_en_d   = 1'b1;
          mem_w_addr_d = ADDR_SIZE'(w_res_base + AW2'(col_q));
          mem_w_data_d = arr_res_data;
          col_d        = col_q + 8'd1;
          if (col_q + 8'd1 == cols_q) begin
            done_d  = 1'b1;
            col_d   = 8'd0;
            t_d     = 9'd0;
            state_d = S_IDLE;
          end
        end
      end

      S_READ_ADDR: begin
        mem_r_en_d   = 1'b1;
        mem_r_addr_d = ADDR_SIZE'(w_res_base + AW2'(col_q));
        state_d      = S_READ_MEM;
      end

      S_READ_MEM: state_d = S_READ_CAP;

      S_READ_CAP: begin
        rsp_data_d  = mem_r_data;
        rsp_valid_d = 1'b1;
        state_d     = S_READ_HOLD;
      end

      S_READ_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (col_q + 8'd1 == cols_q) begin
            col_d   = 8'd0;
            state_d = S_IDLE;
          end else begin
            col_d   = col_q + 8'd1;
            state_d = S_READ_ADDR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = state_d inside {S_IDLE, S_LOAD_VEC, S_LOAD_MAT};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rows_q       <= 8'd1;
      cols_q       <= 8'd1;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= 16'd0;
      t_q          <= 9'd0;
      col_q        <= 8'd0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      mem_w_en_q   <= 1'b0;
      mem_w_addr_q <= '0;
      mem_w_data_q <= '0;
      mem_r_en_q   <= 1'b0;
      mem_r_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      err_q        <= err_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      t_q          <= t_d;
      col_q        <= col_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_w_addr_q <= mem_w_addr_d;
      mem_w_data_q <= mem_w_data_d;
      mem_r_en_q   <= mem_r_en_d;
      mem_r_addr_q <= mem_r_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mv_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mv_seq_ctrl : scoreboard bench for mv_seq_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mv_seq_ctrl;

  localparam int            AW  = 10;
  localparam int            WS  = 16;
  localparam int            PEN = 64;
  localparam logic [AW-1:0] ZA  = '1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic [WS-1:0]     cmd_data = '0;
  logic              rsp_valid, rsp_ready = 1'b0;
  logic [WS-1:0]     rsp_data;
  logic              mem_w_en, mem_r_en;
  logic [AW-1:0]     mem_w_addr, mem_r_addr;
  logic [WS-1:0]     mem_w_data, mem_r_data = '0;
  logic              arr_clear, busy;
  logic [AW-1:0]     vec_addr;
  logic [PEN*AW-1:0] pe_addr;
  logic              arr_res_valid = 1'b0;
  logic [WS-1:0]     arr_res_data = '0;

  mv_seq_ctrl #(
    .ADDR_SIZE(AW), .WORD_SIZE(WS), .PE_NUMBER(PEN), .MAX_COLS(64),
    .MEM_BASE(10'h00f), .ZERO_ADDR(ZA)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .arr_clear(arr_clear), .vec_addr(vec_addr), .pe_addr(pe_addr),
    .arr_res_valid(arr_res_valid), .arr_res_data(arr_res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [WS-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];
  end

  int n_checks = 0;
  int n_fails  = 0;
  logic [25:0] wr_q[$];
  logic [AW-1:0] rd_q[$];
  logic [WS-1:0] rsp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic          stall_prev = 1'b0;
  logic [WS-1:0] held = '0;
  logic [25:0]   e_wr;
  logic [AW-1:0] e_rd;
  logic [WS-1:0] e_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      check_eq("wr_rd_excl", 32'(mem_w_en & mem_r_en), 0);
      if (mem_w_en) begin
        check_eq("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          e_wr = wr_q.pop_front();
          check_eq("wr_addr", 32'(mem_w_addr), 32'(e_wr[25:16]));
          check_eq("wr_data", 32'(mem_w_data), 32'(e_wr[15:0]));
        end
      end
      if (mem_r_en) begin
        check_eq("rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          e_rd = rd_q.pop_front();
          check_eq("rd_addr", 32'(mem_r_addr), 32'(e_rd));
        end
      end
      if (stall_prev) begin
        check_eq("rsp_hold_valid", 32'(rsp_valid), 1);
        check_eq("rsp_hold_data", 32'(rsp_data), 32'(held));
      end
      if (rsp_valid && rsp_ready) begin
        check_eq("rsp_expected", 32'(rsp_q.size() != 0), 1);
        if (rsp_q.size() != 0) begin
          e_rsp = rsp_q.pop_front();
          check_eq("rsp_data", 32'(rsp_data), 32'(e_rsp));
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      held       = rsp_data;
    end
  end

  task automatic send(input logic [WS-1:0] w);
    int n = 0;
    @(posedge clk); #1;
    cmd_data  = w;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check_eq("cmd_ready_timeout", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(input int stall);
    int n = 0;
    @(posedge clk); #1;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("rsp_arrives", 32'(rsp_valid), 1);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic status(input logic [WS-1:0] exp);
    rsp_q.push_back(exp);
    send(16'h7000);
    take_rsp(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [PEN*AW-1:0] all_zero;
    all_zero = {PEN{ZA}};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_eq("ready_after_reset", 32'(cmd_ready), 1);

    // Error handling and sticky err / clear-on-STATUS
    send(16'h6000);
    status(16'h2001);
    status(16'h0001);
    send(16'h1000);
    status(16'h2001);
    send(16'h1041);
    status(16'h2001);
    send(16'hF123);
    status(16'h2001);
    send(16'h1040);
    status(16'h0040);
    send(16'h2041);
    status(16'h2040);

    // Reset in the middle of a matrix load
    send(16'h1004);
    send(16'h2003);
    send(16'h5000);
    wr_q.push_back({10'h013, 16'hAAAA});
    send(16'hAAAA);
    wr_q.push_back({10'h014, 16'hBBBB});
    send(16'hBBBB);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_mem_w_en", 32'(mem_w_en), 0);
    check_eq("rst_mem_r_en", 32'(mem_r_en), 0);
    check_eq("rst_arr_clear", 32'(arr_clear), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_vec_addr", 32'(vec_addr), 32'(ZA));
    check_eq("rst_pe_addr", 32'(pe_addr == all_zero), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_eq("ready_after_mid_reset", 32'(cmd_ready), 1);
    status(16'h0001);

    // Vector and matrix load
    send(16'h1004);
    send(16'h2003);
    send(16'h4000);
    for (int k = 0; k < 4; k++) begin
      wr_q.push_back({AW'(15 + k), 16'(k + 1)});
      send(16'(k + 1));
    end
    send(16'h5000);
    for (int k = 0; k < 12; k++) begin
      logic [WS-1:0] d;
      d = (k == 5) ? 16'h3000 : 16'(16'h0100 + k);
      wr_q.push_back({AW'(19 + k), d});
      send(d);
    end
    status(16'h0004);

    // Compute: fetch, wait, drain with an early result pulse that must be ignored
    send(16'h3000);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j < 6) begin
        check_eq("run_busy", 32'(busy), 1);
        check_eq("run_arr_clear", 32'(arr_clear), 0);
        check_eq("vec_addr", 32'(vec_addr), (j < 4) ? 32'(15 + j) : 32'(ZA));
        check_eq("lane1_addr", 32'(pe_addr[1*AW +: AW]), (j < 3) ? 32'(20 + 4*j) : 32'(ZA));
        check_eq("lane5_addr", 32'(pe_addr[5*AW +: AW]), 32'(ZA));
      end
      if (j == 6) begin
        check_eq("drain_busy", 32'(busy), 1);
        check_eq("drain_vec_addr", 32'(vec_addr), 32'(ZA));
      end
      case (j)
        5: begin arr_res_valid = 1'b1; arr_res_data = 16'hDEAD; end
        6: begin arr_res_data = 16'd7; wr_q.push_back({10'h01f, 16'd7}); end
        7: begin arr_res_data = 16'd8; wr_q.push_back({10'h020, 16'd8}); end
        8: begin arr_res_data = 16'd9; wr_q.push_back({10'h021, 16'd9}); end
        default: ;
      endcase
    end
    @(negedge clk);
    arr_res_valid = 1'b0;
    check_eq("done_busy", 32'(busy), 0);
    check_eq("done_arr_clear", 32'(arr_clear), 1);
    status(16'h4004);

    // Read back with a slow bridge
    for (int c = 0; c < 3; c++) begin
      rd_q.push_back(AW'(31 + c));
      rsp_q.push_back(16'(7 + c));
    end
    send(16'h6000);
    for (int c = 0; c < 3; c++) take_rsp(5);
    status(16'h4004);

    repeat (4) @(posedge clk);
    check_eq("wr_q_drained", 32'(wr_q.size()), 0);
    check_eq("rd_q_drained", 32'(rd_q.size()), 0);
    check_eq("rsp_q_drained", 32'(rsp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
